xif_coproc_frontend: RTL and testbench

- Coprocessor-side endpoint of the CORE-V-XIF issue, commit and result channels for the rvfpm FP coprocessor.
- Decodes offered instructions and returns accept/writeback/loadstore on the issue channel.
- Buffers accepted instructions in an in-order queue until the CPU commits or kills them.
- Dispatches committed instructions to the FPU core and returns FPU results to the CPU through a registered result stage with valid/ready backpressure.

---
 rtl/xif_coproc_frontend.sv | 223 ++++++++++++++++++++++
 tb/tb_xif_coproc_frontend.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_frontend.sv
// CORE-V-XIF coprocessor front end for the rvfpm FPU: issue decode, in-order
// commit queue feeding the FPU, and a registered result stage back to the CPU.
module xif_coproc_frontend #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned X_NUM_RS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [31:0]                issue_instr,
    input  logic [X_ID_WIDTH-1:0]      issue_id,
    input  logic [X_NUM_RS*XLEN-1:0]   issue_rs,
    input  logic [X_NUM_RS-1:0]        issue_rs_valid,
    output logic                       issue_accept,
    output logic                       issue_writeback,
    output logic                       issue_loadstore,

    input  logic                       commit_valid,
    input  logic [X_ID_WIDTH-1:0]      commit_id,
    input  logic                       commit_kill,

    output logic                       fpu_valid,
    input  logic                       fpu_ready,
    output logic [31:0]                fpu_instr,
    output logic [X_ID_WIDTH-1:0]      fpu_id,
    output logic [X_NUM_RS*XLEN-1:0]   fpu_rs,

    input  logic                       res_in_valid,
    output logic                       res_in_ready,
    input  logic [X_ID_WIDTH-1:0]      res_in_id,
    input  logic [XLEN-1:0]            res_in_data,
    input  logic [4:0]                 res_in_rd,
    input  logic                       res_in_we,

    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [X_ID_WIDTH-1:0]      result_id,
    output logic [XLEN-1:0]            result_data,
    output logic [4:0]                 result_rd,
    output logic                       result_we
);

    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned RSW = X_NUM_RS * XLEN;

    localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_STOR_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD    = 7'b1000011;
    localparam logic [6:0] OPC_MSUB    = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_NMADD   = 7'b1001111;

    // ---------------------------------------------------------------- decode
    logic       dec_acc;
    logic       dec_wb;
    logic       dec_ls;
    logic [6:0] opcode;
    logic [4:0] funct5;

    assign opcode = issue_instr[6:0];
    assign funct5 = issue_instr[31:27];

    always_comb begin
        dec_acc = 1'b0;
        dec_wb  = 1'b0;
        dec_ls  = 1'b0;
        case (opcode)
            OPC_OP_FP: begin
                dec_acc = 1'b1;
                // FP compare/classify/move-to-int and FP->int converts write an integer rd
                dec_wb  = (funct5 == 5'b10100) || (funct5 == 5'b11000) || (funct5 == 5'b11100);
            end
            OPC_LOAD_FP, OPC_STOR_FP: begin
                dec_acc = 1'b1;
                dec_ls  = 1'b1;
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                dec_acc = 1'b1;
            end
            default: ;
        endcase
    end

    assign issue_accept    = dec_acc;
    assign issue_writeback = dec_wb;
    assign issue_loadstore = dec_ls;

    // ----------------------------------------------------------------- queue
    logic [31:0]           instr_q [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic [RSW-1:0]        rs_q    [DEPTH];
    logic [DEPTH-1:0]      vld_q;
    logic [DEPTH-1:0]      cmt_q;
    logic [DEPTH-1:0]      kill_q;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  head_cmt;
    logic [DEPTH-1:0]      cm_hit;
    logic                  cm_found;
    logic                  cm_new;
    logic [PW-1:0]         scan_idx;

    // Full check uses the registered count only, so a pop never frees a slot early
    assign issue_ready = !rst && (&issue_rs_valid) && (!dec_acc || (count_q < CW'(DEPTH)));
    assign push        = issue_valid && issue_ready && dec_acc;

    assign head_cmt  = vld_q[head_q] && cmt_q[head_q];
    assign fpu_valid = head_cmt && !kill_q[head_q];
    assign pop       = head_cmt && (kill_q[head_q] || fpu_ready);
    assign fpu_instr = instr_q[head_q];
    assign fpu_id    = id_q[head_q];
    assign fpu_rs    = rs_q[head_q];

    // Scan from the head so a duplicated ID resolves to the oldest entry
    always_comb begin
        cm_hit   = '0;
        cm_found = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + i[PW-1:0];
            if (commit_valid && !cm_found && vld_q[scan_idx] && !cmt_q[scan_idx] &&
                (id_q[scan_idx] == commit_id)) begin
                cm_hit[scan_idx] = 1'b1;
                cm_found         = 1'b1;
            end
        end
        cm_new = commit_valid && push && !cm_found && (issue_id == commit_id);
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                id_q[i]    <= '0;
                rs_q[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cm_hit[i]) begin
                    cmt_q[i]  <= 1'b1;
                    kill_q[i] <= commit_kill;
                end
            end
            if (pop) begin
                vld_q[head_q]  <= 1'b0;
                cmt_q[head_q]  <= 1'b0;
                kill_q[head_q] <= 1'b0;
            end
            if (push) begin
                instr_q[tail_q] <= issue_instr;
                id_q[tail_q]    <= issue_id;
                rs_q[tail_q]    <= issue_rs;
                vld_q[tail_q]   <= 1'b1;
                cmt_q[tail_q]   <= cm_new;
                kill_q[tail_q]  <= cm_new && commit_kill;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------- result stage
    logic                  res_valid_q;
    logic [X_ID_WIDTH-1:0] res_id_q;
    logic [XLEN-1:0]       res_data_q;
    logic [4:0]            res_rd_q;
    logic                  res_we_q;

    assign res_in_ready = !res_valid_q || result_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_we_q    <= 1'b0;
        end else if (res_in_valid && res_in_ready) begin
            res_valid_q <= 1'b1;
            res_id_q    <= res_in_id;
            res_data_q  <= res_in_data;
            res_rd_q    <= res_in_rd;
            res_we_q    <= res_in_we;
        end else if (result_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign result_valid = res_valid_q;
    assign result_id    = res_id_q;
    assign result_data  = res_data_q;
    assign result_rd    = res_rd_q;
    assign result_we    = res_we_q;

endmodule

// File: tb/tb_xif_coproc_frontend.sv
// Self-checking bench for xif_coproc_frontend: decode vector table, scoreboarded
// FPU dispatch and result transfers, and cycle-exact commit/kill/reset sequences.
module tb_xif_coproc_frontend;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic [63:0] issue_rs;
    logic [1:0]  issue_rs_valid;
    logic        issue_accept;
    logic        issue_writeback;
    logic        issue_loadstore;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [31:0] fpu_instr;
    logic [3:0]  fpu_id;
    logic [63:0] fpu_rs;
    logic        res_in_valid;
    logic        res_in_ready;
    logic [3:0]  res_in_id;
    logic [31:0] res_in_data;
    logic [4:0]  res_in_rd;
    logic        res_in_we;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;

    xif_coproc_frontend #(
        .XLEN       (32),
        .X_ID_WIDTH (4),
        .X_NUM_RS   (2),
        .DEPTH      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_instr     (issue_instr),
        .issue_id        (issue_id),
        .issue_rs        (issue_rs),
        .issue_rs_valid  (issue_rs_valid),
        .issue_accept    (issue_accept),
        .issue_writeback (issue_writeback),
        .issue_loadstore (issue_loadstore),
        .commit_valid    (commit_valid),
        .commit_id       (commit_id),
        .commit_kill     (commit_kill),
        .fpu_valid       (fpu_valid),
        .fpu_ready       (fpu_ready),
        .fpu_instr       (fpu_instr),
        .fpu_id          (fpu_id),
        .fpu_rs          (fpu_rs),
        .res_in_valid    (res_in_valid),
        .res_in_ready    (res_in_ready),
        .res_in_id       (res_in_id),
        .res_in_data     (res_in_data),
        .res_in_rd       (res_in_rd),
        .res_in_we       (res_in_we),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_id       (result_id),
        .result_data     (result_data),
        .result_rd       (result_rd),
        .result_we       (result_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  rsv;
        logic        acc;
        logic        wb;
        logic        ls;
        logic        rdy;
    } dec_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  id;
        logic [63:0] rs;
    } fpu_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_exp_t;

    localparam int NV = 14;
    dec_vec_t vecs [NV];
    fpu_exp_t fpu_sb [$];
    res_exp_t res_sb [$];
    fpu_exp_t fe;
    res_exp_t re;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] FADD = 32'h00208053;
    localparam logic [31:0] FSUB = 32'h08208053;
    localparam logic [31:0] FMUL = 32'h10208053;
    localparam logic [31:0] ADDI = 32'h00000013;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] rs_of(input logic [31:0] ins, input logic [3:0] id);
        return {ins ^ 32'hA5A5A5A5, 28'hC0FFEE0, id};
    endfunction

    // Start of a cycle: all strobes low, inputs changed on the falling edge
    task automatic step();
        @(negedge clk);
        issue_valid    = 1'b0;
        commit_valid   = 1'b0;
        commit_kill    = 1'b0;
        res_in_valid   = 1'b0;
        issue_rs_valid = 2'b11;
    endtask

    task automatic do_issue(input logic [31:0] ins, input logic [3:0] id);
        issue_valid = 1'b1;
        issue_instr = ins;
        issue_id    = id;
        issue_rs    = rs_of(ins, id);
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    task automatic expect_disp(input logic [31:0] ins, input logic [3:0] id);
        fpu_sb.push_back('{instr: ins, id: id, rs: rs_of(ins, id)});
    endtask

    // Handshake monitors sample just before the rising edge that completes a transfer
    always begin
        @(negedge clk);
        #4;
        if (!rst && fpu_valid && fpu_ready) begin
            if (fpu_sb.size() == 0) chk("fpu_unexpected_dispatch", 64'd1, 64'd0);
            else begin
                fe = fpu_sb.pop_front();
                chk("disp_instr", 64'(fpu_instr), 64'(fe.instr));
                chk("disp_id", 64'(fpu_id), 64'(fe.id));
                chk("disp_rs", fpu_rs, fe.rs);
            end
        end
        if (!rst && result_valid && result_ready) begin
            if (res_sb.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
            else begin
                re = res_sb.pop_front();
                chk("res_id", 64'(result_id), 64'(re.id));
                chk("res_data", 64'(result_data), 64'(re.data));
                chk("res_rd", 64'(result_rd), 64'(re.rd));
                chk("res_we", 64'(result_we), 64'(re.we));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{FADD,          2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'hE0000553, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{ADDI,          2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h00002007, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{32'h00002027, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{32'hA0000553, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'hC0000553, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h00000043, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h00000047, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000004B, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h0000004F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'hE0000033, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{FADD,          2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{ADDI,          2'b10, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        issue_valid = 1'b0; issue_instr = FADD; issue_id = '0; issue_rs = '0; issue_rs_valid = 2'b11;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
        fpu_ready = 1'b1;
        res_in_valid = 1'b0; res_in_id = '0; res_in_data = '0; res_in_rd = '0; res_in_we = 1'b0;
        result_ready = 1'b0;

        #1;
        chk("rst_issue_ready", 64'(issue_ready), 64'd0);
        chk("rst_fpu_valid", 64'(fpu_valid), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_result_fields", {result_id, result_data, result_rd, result_we}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Decode table against an empty queue, no handshake
        for (int i = 0; i < NV; i++) begin
            step();
            issue_instr    = vecs[i].instr;
            issue_rs_valid = vecs[i].rsv;
            #1;
            chk($sformatf("dec%0d_accept", i), 64'(issue_accept), 64'(vecs[i].acc));
            chk($sformatf("dec%0d_wb", i), 64'(issue_writeback), 64'(vecs[i].wb));
            chk($sformatf("dec%0d_ls", i), 64'(issue_loadstore), 64'(vecs[i].ls));
            chk($sformatf("dec%0d_ready", i), 64'(issue_ready), 64'(vecs[i].rdy));
        end

        // FADD id 3: commit next cycle, dispatch one cycle after the commit
        step(); do_issue(FADD, 4'd3); #1;
        chk("s1_accept", 64'(issue_accept), 64'd1);
        chk("s1_ready", 64'(issue_ready), 64'd1);
        step(); do_commit(4'd3, 1'b0); expect_disp(FADD, 4'd3); #1;
        chk("s1_commit_cycle_fpu_valid", 64'(fpu_valid), 64'd0);
        step(); #1;
        chk("s1_fpu_valid", 64'(fpu_valid), 64'd1);
        chk("s1_fpu_instr", 64'(fpu_instr), 64'(FADD));
        chk("s1_fpu_id", 64'(fpu_id), 64'd3);
        step(); #1;
        chk("s1_after_pop", 64'(fpu_valid), 64'd0);

        // FMV.X.W accepted then killed; ADDI rejected leaves no entry
        step(); do_issue(32'hE0000553, 4'd4); #1;
        chk("s2_fmv_wb", 64'(issue_writeback), 64'd1);
        step(); do_issue(ADDI, 4'd6); do_commit(4'd4, 1'b1); #1;
        chk("s2_addi_accept", 64'(issue_accept), 64'd0);
        chk("s2_addi_ready", 64'(issue_ready), 64'd1);
        step(); do_commit(4'd6, 1'b0); #1;
        chk("s2_killed_silent", 64'(fpu_valid), 64'd0);
        step(); #1;
        chk("s2_addi_not_queued", 64'(fpu_valid), 64'd0);

        // Fill to DEPTH, then full checks including no push-on-pop bypass
        for (int i = 0; i < 4; i++) begin
            step(); do_issue(FADD | (32'(i) << 7), 4'(i)); #1;
            chk($sformatf("s3_fill%0d_ready", i), 64'(issue_ready), 64'd1);
        end
        step(); issue_instr = FADD; #1;
        chk("s3_full_fp_ready", 64'(issue_ready), 64'd0);
        issue_instr = ADDI; #1;
        chk("s3_full_nonfp_ready", 64'(issue_ready), 64'd1);
        issue_instr = FADD;
        do_commit(4'd0, 1'b0); expect_disp(FADD, 4'd0);
        for (int i = 1; i < 4; i++) begin
            step(); issue_instr = FADD;
            do_commit(4'(i), 1'b0); expect_disp(FADD | (32'(i) << 7), 4'(i)); #1;
            if (i == 1) begin
                chk("s3_pop_cycle_fpu_valid", 64'(fpu_valid), 64'd1);
                chk("s3_no_bypass_ready", 64'(issue_ready), 64'd0);
            end
        end
        for (int t = 0; t < 12 && fpu_sb.size() != 0; t++) step();
        chk("s3_drain", 64'(fpu_sb.size()), 64'd0);

        // Kill id 1 after 2 and 3 commit: nothing dispatches until 1 resolves
        for (int i = 1; i < 4; i++) begin
            step(); do_issue(FMUL, 4'(i));
        end
        step(); do_commit(4'd2, 1'b0); expect_disp(FMUL, 4'd2);
        step(); do_commit(4'd3, 1'b0); expect_disp(FMUL, 4'd3); #1;
        chk("s4_blocked_a", 64'(fpu_valid), 64'd0);
        step(); do_commit(4'd1, 1'b1); #1;
        chk("s4_blocked_b", 64'(fpu_valid), 64'd0);
        step(); #1;
        chk("s4_kill_silent", 64'(fpu_valid), 64'd0);
        step(); #1;
        chk("s4_disp2_valid", 64'(fpu_valid), 64'd1);
        chk("s4_disp2_id", 64'(fpu_id), 64'd2);
        step(); #1;
        chk("s4_disp3_valid", 64'(fpu_valid), 64'd1);
        chk("s4_disp3_id", 64'(fpu_id), 64'd3);
        step(); #1;
        chk("s4_empty", 64'(fpu_valid), 64'd0);

        // Duplicate ids: only the oldest matches; commit in the push cycle
        step(); do_issue(FADD, 4'd5);
        step(); do_issue(FSUB, 4'd5);
        step(); do_commit(4'd5, 1'b0); expect_disp(FADD, 4'd5);
        step(); #1;
        chk("s5_dup_oldest", 64'(fpu_instr), 64'(FADD));
        step(); #1;
        chk("s5_dup_younger_held", 64'(fpu_valid), 64'd0);
        do_commit(4'd5, 1'b0); expect_disp(FSUB, 4'd5);
        step(); #1;
        chk("s5_dup_second", 64'(fpu_instr), 64'(FSUB));
        step(); do_issue(FMUL, 4'd7); do_commit(4'd7, 1'b0); expect_disp(FMUL, 4'd7);
        step(); #1;
        chk("s5_same_cycle_commit", 64'(fpu_valid), 64'd1);
        step(); #1;
        chk("s5_after", 64'(fpu_valid), 64'd0);

        // Result backpressure then back-to-back transfer
        step(); result_ready = 1'b0;
        res_in_valid = 1'b1; res_in_id = 4'd5; res_in_data = 32'hDEADBEEF; res_in_rd = 5'd10; res_in_we = 1'b1;
        res_sb.push_back('{id: 4'd5, data: 32'hDEADBEEF, rd: 5'd10, we: 1'b1}); #1;
        chk("s6_in_ready_empty", 64'(res_in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            res_in_valid = 1'b1; res_in_id = 4'd6; res_in_data = 32'h12345678; res_in_rd = 5'd3; res_in_we = 1'b0; #1;
            chk($sformatf("s6_hold%0d_in_ready", c), 64'(res_in_ready), 64'd0);
            chk($sformatf("s6_hold%0d", c), {result_valid, result_id, result_data}, {1'b1, 4'd5, 32'hDEADBEEF});
        end
        step(); result_ready = 1'b1;
        res_in_valid = 1'b1; res_in_id = 4'd6; res_in_data = 32'h12345678; res_in_rd = 5'd3; res_in_we = 1'b0;
        res_sb.push_back('{id: 4'd6, data: 32'h12345678, rd: 5'd3, we: 1'b0}); #1;
        chk("s6_b2b_in_ready", 64'(res_in_ready), 64'd1);
        step(); #1;
        chk("s6_second", {result_valid, result_id}, {1'b1, 4'd6});
        step(); #1;
        chk("s6_drained", 64'(result_valid), 64'd0);
        result_ready = 1'b0;

        // Reset with committed entries and a held result pending
        fpu_ready = 1'b0;
        step(); do_issue(FADD, 4'd8);
        step(); do_issue(FSUB, 4'd9); do_commit(4'd8, 1'b0);
        step(); do_commit(4'd9, 1'b0);
        res_in_valid = 1'b1; res_in_id = 4'd2; res_in_data = 32'hCAFEF00D; res_in_rd = 5'd1; res_in_we = 1'b1;
        step(); #1;
        chk("s7_pending_fpu", 64'(fpu_valid), 64'd1);
        chk("s7_pending_result", 64'(result_valid), 64'd1);
        rst = 1'b1; #1;
        chk("s7_rst_fpu_valid", 64'(fpu_valid), 64'd0);
        chk("s7_rst_result", {result_valid, result_id, result_data}, 37'd0);
        chk("s7_rst_issue_ready", 64'(issue_ready), 64'd0);
        step(); rst = 1'b0; fpu_ready = 1'b1; result_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            chk($sformatf("s7_post%0d_fpu_valid", c), 64'(fpu_valid), 64'd0);
        end

        chk("end_fpu_sb_empty", 64'(fpu_sb.size()), 64'd0);
        chk("end_res_sb_empty", 64'(res_sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
